// File: rtl/alloc_dispatcher_pkg.sv
// Shared sizes, codes and state encoding for the allocation dispatcher.
package alloc_dispatcher_pkg;

  localparam int REQ_ID_WIDTH        = 8;
  localparam int REQ_SIZE_TYPE_WIDTH = 2;

  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_512 = 2'd0;
  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_1K  = 2'd1;
  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_2K  = 2'd2;
  localparam logic [REQ_SIZE_TYPE_WIDTH-1:0] REQ_4K  = 2'd3;

  localparam int DSP_INFLIGHT_WIDTH = 4;
  localparam int DSP_SETTLE_WIDTH   = 4;
  localparam int DSP_REPLAY_WIDTH   = 8;

  typedef enum logic [2:0] {
    DSP_IDLE   = 3'd0,
    DSP_ISSUE  = 3'd1,
    DSP_CHECK  = 3'd2,
    DSP_WAIT   = 3'd3,
    DSP_SETTLE = 3'd4
  } dsp_state_e;

  typedef struct packed {
    logic [REQ_ID_WIDTH-1:0]        id;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] size;
    logic [REQ_SIZE_TYPE_WIDTH-1:0] origin_size;
  } dsp_req_t;

endpackage

// File: rtl/alloc_dispatcher_inflight_counter.sv
// Count of allocations accepted into the AT tree and not yet completed.
module inflight_counter
  import alloc_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH = DSP_INFLIGHT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_in,
  input  logic             dec_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             dec_eff;

  // Next count: a completion at zero is dropped, inc+dec cancel.
  always_comb begin
    count_d = count_q;
    dec_eff = dec_in && (count_q != '0);
    if (inc_in && !dec_eff) begin
      count_d = count_q + WIDTH'(1);
    end else if (!inc_in && dec_eff) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/alloc_dispatcher.sv
// Front-end scheduler: issues requests to the find table one at a time,
// holds and replays a request that hit a full table, and bounds the
// number of allocations in flight.
module alloc_dispatcher
  import alloc_dispatcher_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT  = 4,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid_in,
  output logic                           req_ready_out,
  input  logic [REQ_ID_WIDTH-1:0]        req_id_in,
  input  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_size_in,
  input  logic [REQ_SIZE_TYPE_WIDTH-1:0] req_origin_size_in,
  output logic                           alloc_valid_fdt_out,
  output logic [REQ_ID_WIDTH-1:0]        alloc_id_fdt_out,
  output logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_size_fdt_out,
  output logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_origin_size_fdt_out,
  input  logic                           fdt_blocked_in,
  input  logic                           fdt_update_valid_in,
  input  logic                           alloc_done_in,
  output logic                           blocked_out,
  output logic [DSP_REPLAY_WIDTH-1:0]    replay_cnt_out
);

  localparam logic [DSP_INFLIGHT_WIDTH-1:0] MAX_L    = DSP_INFLIGHT_WIDTH'(MAX_INFLIGHT);
  localparam logic [DSP_SETTLE_WIDTH-1:0]   SETTLE_L = DSP_SETTLE_WIDTH'(SETTLE_CYCLES);

  dsp_state_e                    state_q, state_d;
  dsp_req_t                      hold_q, hold_d;
  logic [DSP_SETTLE_WIDTH-1:0]   settle_q, settle_d;
  logic [DSP_REPLAY_WIDTH-1:0]   replay_q, replay_d;
  logic                          alive_q;
  logic                          inflight_inc;
  logic [DSP_INFLIGHT_WIDTH-1:0] inflight;
  logic                          ready;

  inflight_counter #(
    .WIDTH (DSP_INFLIGHT_WIDTH)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_in    (inflight_inc),
    .dec_in    (alloc_done_in),
    .count_out (inflight)
  );

  // alive_q keeps ready low while in reset and releases it one edge later;
  // ready is otherwise decoded from registered state only.
  assign ready = alive_q && (state_q == DSP_IDLE) && (inflight < MAX_L);

  // Next-state logic for the issue/check/replay sequence.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    settle_d     = settle_q;
    replay_d     = replay_q;
    inflight_inc = 1'b0;
    unique case (state_q)
      DSP_IDLE: begin
        if (req_valid_in && ready) begin
          hold_d  = '{id: req_id_in, size: req_size_in, origin_size: req_origin_size_in};
          state_d = DSP_ISSUE;
        end
      end
      DSP_ISSUE: begin
        state_d = DSP_CHECK;
      end
      DSP_CHECK: begin
        if (!fdt_blocked_in) begin
          inflight_inc = 1'b1;
          state_d      = DSP_IDLE;
        end else if (fdt_update_valid_in) begin
          settle_d = SETTLE_L;
          state_d  = DSP_SETTLE;
        end else begin
          state_d = DSP_WAIT;
        end
      end
      DSP_WAIT: begin
        if (fdt_update_valid_in) begin
          settle_d = SETTLE_L;
          state_d  = DSP_SETTLE;
        end
      end
      DSP_SETTLE: begin
        if (settle_q <= DSP_SETTLE_WIDTH'(1)) begin
          state_d = DSP_ISSUE;
          if (replay_q != '1) begin
            replay_d = replay_q + DSP_REPLAY_WIDTH'(1);
          end
        end else begin
          settle_d = settle_q - DSP_SETTLE_WIDTH'(1);
        end
      end
      default: begin
        state_d = DSP_IDLE;
      end
    endcase
  end

  // State, hold register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DSP_IDLE;
      hold_q   <= '0;
      settle_q <= '0;
      replay_q <= '0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      settle_q <= settle_d;
      replay_q <= replay_d;
      alive_q  <= 1'b1;
    end
  end

  assign req_ready_out             = ready;
  assign alloc_valid_fdt_out       = (state_q == DSP_ISSUE);
  assign alloc_id_fdt_out          = hold_q.id;
  assign alloc_size_fdt_out        = hold_q.size;
  assign alloc_origin_size_fdt_out = hold_q.origin_size;
  assign blocked_out               = (state_q == DSP_WAIT) || (state_q == DSP_SETTLE);
  assign replay_cnt_out            = replay_q;

endmodule

// File: doc/alloc_dispatcher.md
# alloc_dispatcher

Front-end scheduler for the find table. It accepts allocation requests over a valid/ready handshake and issues them one at a time on the find table's alloc port. It checks the find table's blocked flag after every issue. If the table was full, it holds the request, snoops find-table update traffic, and replays the same request once a slot is freed. It also bounds the number of allocations outstanding in the AT tree.

## Interface
Parameters:
- MAX_INFLIGHT, 4: maximum accepted-but-not-completed allocations; range 1..15.
- SETTLE_CYCLES, 3: wait after a snooped update before replay, so the find-table mask and RAM write settle; range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_in  in  1  request present.
- req_ready_out  out  1  dispatcher can accept.
- req_id_in  in  `REQ_ID_WIDTH  request id.
- req_size_in  in  `REQ_SIZE_TYPE_WIDTH  aligned size code (`REQ_512/`REQ_1K/`REQ_2K/`REQ_4K).
- req_origin_size_in  in  `REQ_SIZE_TYPE_WIDTH  original size code, passed through.
- alloc_valid_fdt_out  out  1  one-cycle issue strobe to the find table.
- alloc_id_fdt_out, alloc_size_fdt_out, alloc_origin_size_fdt_out  out  widths as above  issued fields.
- fdt_blocked_in  in  1  find-table blocked flag (registered in the find table).
- fdt_update_valid_in  in  1  snoop of the AT-tree update strobe into the find table.
- alloc_done_in  in  1  one allocation completed downstream; frees an in-flight slot.
- blocked_out  out  1  high while holding a blocked request.
- replay_cnt_out  out  8  saturating count of replays since reset.

## Operation
- States: IDLE, ISSUE, CHECK, WAIT, SETTLE.
- IDLE:
  - req_ready_out = (inflight < MAX_INFLIGHT).
  - On handshake (valid & ready): capture id, size and origin size into a hold register; go to ISSUE.
- ISSUE:
  - alloc_valid_fdt_out = 1, fields from the hold register; go to CHECK.
- CHECK: sample fdt_blocked_in, which reflects the issue made in the previous cycle.
  - Blocked = 0: inflight += 1; go to IDLE.
  - Blocked = 1 and fdt_update_valid_in = 1 in the same cycle: go to SETTLE.
  - Blocked = 1 otherwise: go to WAIT.
- WAIT:
  - blocked_out = 1.
  - On fdt_update_valid_in: load the settle counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - blocked_out = 1; the counter decrements each cycle.
  - Updates arriving in SETTLE do not reload the counter.
  - When the counter reaches 1: go to ISSUE, replaying the held request unchanged (same id); replay_cnt_out += 1, saturating at 255.
- In-flight counter:
  - 4 bits, decremented by alloc_done_in.
  - Increment and decrement in the same cycle: count unchanged.
  - alloc_done_in while the count is 0: ignored, no underflow.
- The hold register is written only on handshake. Issued fields stay stable from ISSUE until the next handshake.
- An unsupported size code is issued as-is; size checking is upstream's responsibility.

## Timing
- Reset values: req_ready_out 0 during reset and 1 from the first cycle after deassertion; alloc_valid_fdt_out 0; all issued fields 0; blocked_out 0; replay_cnt_out 0; state IDLE; in-flight count 0.
- All outputs are registered or decoded from state only. There is no combinational path from req_valid_in to any output.
- Handshake at edge E: the issue strobe is high in the cycle following E; the blocked check happens the cycle after that. Minimum spacing is 3 cycles per request: IDLE, ISSUE, CHECK.
- Replay latency: update strobe seen in WAIT at cycle t → re-issue at cycle t+1+SETTLE_CYCLES.
- Reset asserted mid-operation: the state machine returns to IDLE immediately and any held request is discarded. Upstream must re-present it.

## Structure
- Size codes and id/size widths come from mmu_param.vh.
- Add to the shared header: the state encoding macros (`DSP_IDLE..`DSP_SETTLE, 3 bits) and the `DSP_INFLIGHT_WIDTH macro.
- No sub-module is required. The design is a single state machine plus counters. The in-flight counter may be factored as `inflight_counter` if it is reused by the free path.

## Test plan
- Reset, then req id=5, size=`REQ_1K with fdt_blocked_in held 0 → alloc_valid high for 1 cycle with id=5, size=`REQ_1K, 1 cycle after handshake; ready returns 2 cycles later; inflight=1.
- MAX_INFLIGHT=4: five back-to-back requests, no alloc_done → 4 issued, ready low after the 4th; one alloc_done → 5th accepted.
- fdt_blocked_in=1 on CHECK for id=9 → blocked_out=1, no strobe. fdt_update_valid pulse at cycle t → re-issue of id=9 at t+4; replay_cnt_out=1.
- Update pulse coincident with the blocked CHECK → goes directly to SETTLE; replay at t+4. A second update during SETTLE does not delay it.
- alloc_done coincident with a successful CHECK → inflight unchanged. alloc_done at inflight 0 → stays 0.
- rst_n asserted while in WAIT → all outputs at reset values within the same cycle; after release the next request is issued normally, and the held id is never re-issued.
